// File: rtl/r16_tf_gen_pkg.sv
// r16_tf_gen_pkg: shared widths, lane count, multiplier latency and FSM encoding for the radix-16 twiddle generator
package r16_tf_gen_pkg;
    localparam int D_width = 64;
    localparam int CNT_W   = 16;
    localparam int MUL_LAT = 3;
    localparam int LANES   = 16;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/r16_tf_gen_mulmod.sv
// r16_tf_gen_mulmod: pipelined modular multiplier q = (a*b) mod n, MUL_LAT register stages
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           launch strobe, travels alongside the operands
//   a, b, n            operands (a, b < n) and modulus
//   out_valid, q       result strobe and result, MUL_LAT edges after launch
module r16_tf_gen_mulmod
    import r16_tf_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [D_width-1:0] a,
    input  logic [D_width-1:0] b,
    input  logic [D_width-1:0] n,
    output logic               out_valid,
    output logic [D_width-1:0] q
);
    logic [D_width-1:0]   a1, b1, n1, n2;
    logic [2*D_width-1:0] p2;
    logic [MUL_LAT-1:0]   vld;
    // The valid shift register is what lets reset discard in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            a1  <= '0;
            b1  <= '0;
            n1  <= '0;
            n2  <= '0;
            p2  <= '0;
            q   <= '0;
        end else begin
            vld <= {vld[MUL_LAT-2:0], in_valid};
            a1  <= a;
            b1  <= b;
            n1  <= n;
            p2  <= (2*D_width)'(a1) * (2*D_width)'(b1);
            n2  <= n1;
            q   <= D_width'(p2 % (2*D_width)'(n2));
        end
    end
    assign out_valid = vld[MUL_LAT-1];
endmodule

// File: rtl/r16_tf_gen.sv
// r16_tf_gen: radix-16 twiddle generator, emits TF_j = omega^(j*k) mod N for k = 0..K-1
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   N_in, omega_in, K_in    modulus, stage root, vector count (sampled on start in IDLE)
//   start                   one-cycle request, ignored outside IDLE
//   tf_ready                downstream accepts the current vector
//   TF_out0..TF_out15       twiddle vector lanes
//   tf_valid                TF_out* hold a valid vector
//   busy                    high in SEED/RUN
//   done                    one-cycle pulse after the last vector is accepted
//   group_idx_out           k of the vector on TF_out* (only with TF_GEN_IDX_EN defined)
module r16_tf_gen
    import r16_tf_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_width-1:0] N_in,
    input  logic [D_width-1:0] omega_in,
    input  logic [CNT_W-1:0]   K_in,
    input  logic               start,
    input  logic               tf_ready,
    output logic [D_width-1:0] TF_out0,
    output logic [D_width-1:0] TF_out1,
    output logic [D_width-1:0] TF_out2,
    output logic [D_width-1:0] TF_out3,
    output logic [D_width-1:0] TF_out4,
    output logic [D_width-1:0] TF_out5,
    output logic [D_width-1:0] TF_out6,
    output logic [D_width-1:0] TF_out7,
    output logic [D_width-1:0] TF_out8,
    output logic [D_width-1:0] TF_out9,
    output logic [D_width-1:0] TF_out10,
    output logic [D_width-1:0] TF_out11,
    output logic [D_width-1:0] TF_out12,
    output logic [D_width-1:0] TF_out13,
    output logic [D_width-1:0] TF_out14,
    output logic [D_width-1:0] TF_out15,
    output logic               tf_valid,
    output logic               busy,
`ifdef TF_GEN_IDX_EN
    output logic [CNT_W-1:0]   group_idx_out,
`endif
    output logic               done
);
    state_t             state, state_nxt;
    logic [D_width-1:0] n_r, omega_r, n_op;
    logic [CNT_W-1:0]   k_max, k;
    logic [D_width-1:0] acc  [LANES];
    logic [D_width-1:0] step [1:LANES-1];
    logic [D_width-1:0] q    [1:LANES-1];
    logic [LANES-1:1]   vq;
    logic               hs, last, run_go, seed_go;

    assign hs      = tf_valid & tf_ready;
    assign last    = k == k_max - CNT_W'(1);
    assign run_go  = state == S_RUN && hs && !last;
    assign seed_go = state == S_IDLE && start && K_in != '0;
    // Lane 2's first seed round launches on the start edge itself, before N/omega are registered.
    assign n_op    = state == S_IDLE ? N_in : n_r;

    for (genvar j = 1; j < LANES; j++) begin : g_lane
        logic               go;
        logic [D_width-1:0] op_a, op_b;
        if (j < 3) begin : g_head
            assign go   = run_go | (j == 2 && seed_go);
            assign op_a = state == S_RUN ? acc[j] : omega_in;
        end else begin : g_tail
            // Seed chain: lane j starts on the edge lane j-1 lands, taking its result straight off the multiplier.
            assign go   = run_go | (state == S_SEED && vq[j-1]);
            assign op_a = state == S_RUN ? acc[j] : q[j-1];
        end
        assign op_b = state == S_RUN ? step[j] : state == S_IDLE ? omega_in : omega_r;
        r16_tf_gen_mulmod u_mul (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (go),
            .a         (op_a),
            .b         (op_b),
            .n         (n_op),
            .out_valid (vq[j]),
            .q         (q[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = !start ? S_IDLE : K_in == '0 ? S_DONE : S_SEED;
            S_SEED:  state_nxt = vq[LANES-1] ? S_RUN : S_SEED;
            S_RUN:   state_nxt = hs && last ? S_DONE : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = state == S_SEED || state == S_RUN;
        done = state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r      <= '0;
            omega_r  <= '0;
            k_max    <= '0;
            k        <= '0;
            tf_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
            for (int i = 1; i < LANES; i++) step[i] <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                n_r     <= N_in;
                omega_r <= omega_in;
                k_max   <= K_in;
                step[1] <= omega_in;
            end
            for (int i = 1; i < LANES; i++) begin
                if (vq[i] && state == S_SEED) step[i] <= q[i];
                if (vq[i] && state == S_RUN)  acc[i]  <= q[i];
            end
            if (state == S_SEED && vq[LANES-1]) begin
                for (int i = 0; i < LANES; i++) acc[i] <= D_width'(1);
                k        <= '0;
                tf_valid <= 1'b1;
            end else if (hs) begin
                k        <= k + CNT_W'(1);
                tf_valid <= 1'b0;
            end else if (state == S_RUN && vq[1]) begin
                tf_valid <= 1'b1;
            end
        end
    end

`ifdef TF_GEN_IDX_EN
    assign group_idx_out = k;
`endif

    assign TF_out0  = acc[0];
    assign TF_out1  = acc[1];
    assign TF_out2  = acc[2];
    assign TF_out3  = acc[3];
    assign TF_out4  = acc[4];
    assign TF_out5  = acc[5];
    assign TF_out6  = acc[6];
    assign TF_out7  = acc[7];
    assign TF_out8  = acc[8];
    assign TF_out9  = acc[9];
    assign TF_out10 = acc[10];
    assign TF_out11 = acc[11];
    assign TF_out12 = acc[12];
    assign TF_out13 = acc[13];
    assign TF_out14 = acc[14];
    assign TF_out15 = acc[15];
endmodule
